// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, control inputs from
// downstream stages, and the IF/ID pipeline register handed to decode.
//   master : the fetch stage (drives imem_addr and the IF/ID fields)
//   slave  : the surrounding core (memory, hazard/branch logic, decoder)
interface instruction_fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        fetch_done;
  logic [31:0] instr_count;

  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect_valid,
    input  redirect_target,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output fetch_done,
    output instr_count
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect_valid,
    output redirect_target,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  fetch_done,
    input  instr_count
  );

endinterface

// File: rtl/instruction_fetch.sv
// Program counter and IF/ID pipeline register of the uPower core.
// Presents the word-address PC to instruction memory, captures the
// returned instruction with its PC into IF/ID, and handles stall,
// branch redirect and end-of-program halt.
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - instruction_fetch_if.master: imem_addr/imem_data,
//              stall, redirect_valid/redirect_target, if_id_valid,
//              if_id_instr, if_id_pc, fetch_done, instr_count
module instruction_fetch #(
  parameter int unsigned IMEM_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h6000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  instruction_fetch_if.master        bus
);

  localparam int unsigned XLEN = 32;

  // Action taken at the next edge, already resolved by priority.
  typedef enum logic [1:0] {
    ACT_FETCH    = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_HALT     = 2'd2,
    ACT_REDIRECT = 2'd3
  } act_e;

  logic [XLEN-1:0] pc_q,    pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q,  ifpc_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            fetch_done_c;
  act_e            act_c;

  // PC outside memory means the program has run off its end.
  assign fetch_done_c = (pc_q >= XLEN'(IMEM_DEPTH));

  // Edge action: redirect > stall > halted > normal fetch.
  always_comb begin
    act_c = ACT_FETCH;
    if (bus.redirect_valid) begin
      act_c = ACT_REDIRECT;
    end else if (bus.stall) begin
      act_c = ACT_STALL;
    end else if (fetch_done_c) begin
      act_c = ACT_HALT;
    end
  end

  // Next-state for PC, IF/ID and delivered-instruction counter.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    count_d = count_q;

    case (act_c)
      ACT_REDIRECT: begin
        // Target is an absolute word index computed by the resolving stage.
        pc_d    = bus.redirect_target;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        ifpc_d  = '0;
      end
      ACT_STALL: begin
        // Everything holds.
      end
      ACT_HALT: begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
        ifpc_d  = '0;
      end
      default: begin
        valid_d = 1'b1;
        instr_d = bus.imem_data;
        ifpc_d  = pc_q;
        pc_d    = pc_q + XLEN'(1);
        count_d = count_q + XLEN'(1);
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      count_q <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.fetch_done  = fetch_done_c;
  assign bus.if_id_valid = valid_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_pc    = ifpc_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, straight-line fetch to
// end of program, stall, redirect, redirect+stall, redirect while halted
// and asynchronous reset mid-stream. A 4-word memory model answers
// imem_addr combinationally.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h6000_0000;
  localparam logic [31:0] OOR = 32'hDEAD_BEEF;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fails;

  logic [31:0] mem [4] = '{32'h3821_0001, 32'h3842_0002, 32'h7C22_1A14, 32'h4800_0000};

  instruction_fetch_if bus ();

  instruction_fetch #(
    .IMEM_DEPTH (4),
    .RESET_PC   (32'h0),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.imem_data = (bus.imem_addr < 32'd4) ? mem[bus.imem_addr[1:0]] : OOR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'h0;
    #12;
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL reset_instr: got %h expected %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.if_id_pc !== 32'h0) begin n_fails++; $display("FAIL reset_pc: got %h expected 0", bus.if_id_pc); end
    n_checks++; if (bus.instr_count !== 32'h0) begin n_fails++; $display("FAIL reset_count: got %0d expected 0", bus.instr_count); end
    n_checks++; if (bus.imem_addr !== 32'h0) begin n_fails++; $display("FAIL reset_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (bus.fetch_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", bus.fetch_done); end
  endtask

  task automatic test_sequential();
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fails++; $display("FAIL seq_valid[%0d]: got %b expected 1", k, bus.if_id_valid); end
      n_checks++; if (bus.if_id_instr !== mem[k]) begin n_fails++; $display("FAIL seq_instr[%0d]: got %h expected %h", k, bus.if_id_instr, mem[k]); end
      n_checks++; if (bus.if_id_pc !== 32'(k)) begin n_fails++; $display("FAIL seq_pc[%0d]: got %h expected %h", k, bus.if_id_pc, 32'(k)); end
      n_checks++; if (bus.instr_count !== 32'(k + 1)) begin n_fails++; $display("FAIL seq_count[%0d]: got %0d expected %0d", k, bus.instr_count, k + 1); end
    end
    n_checks++; if (bus.fetch_done !== 1'b1) begin n_fails++; $display("FAIL seq_done: got %b expected 1", bus.fetch_done); end
    n_checks++; if (bus.imem_addr !== 32'd4) begin n_fails++; $display("FAIL seq_addr: got %h expected 4", bus.imem_addr); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL halt_valid[%0d]: got %b expected 0", k, bus.if_id_valid); end
      n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL halt_instr[%0d]: got %h expected %h", k, bus.if_id_instr, NOP); end
      n_checks++; if (bus.if_id_pc !== 32'h0) begin n_fails++; $display("FAIL halt_pc[%0d]: got %h expected 0", k, bus.if_id_pc); end
      n_checks++; if (bus.instr_count !== 32'd4) begin n_fails++; $display("FAIL halt_count[%0d]: got %0d expected 4", k, bus.instr_count); end
      n_checks++; if (bus.fetch_done !== 1'b1) begin n_fails++; $display("FAIL halt_done[%0d]: got %b expected 1", k, bus.fetch_done); end
      n_checks++; if (bus.imem_addr !== 32'd4) begin n_fails++; $display("FAIL halt_addr[%0d]: got %h expected 4", k, bus.imem_addr); end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[1]) begin n_fails++; $display("FAIL pre_stall_instr: got %h expected %h", bus.if_id_instr, mem[1]); end
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.if_id_instr !== mem[1]) begin n_fails++; $display("FAIL stall_instr[%0d]: got %h expected %h", k, bus.if_id_instr, mem[1]); end
      n_checks++; if (bus.if_id_pc !== 32'd1) begin n_fails++; $display("FAIL stall_ifpc[%0d]: got %h expected 1", k, bus.if_id_pc); end
      n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fails++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, bus.if_id_valid); end
      n_checks++; if (bus.imem_addr !== 32'd2) begin n_fails++; $display("FAIL stall_addr[%0d]: got %h expected 2", k, bus.imem_addr); end
      n_checks++; if (bus.instr_count !== 32'd2) begin n_fails++; $display("FAIL stall_count[%0d]: got %0d expected 2", k, bus.instr_count); end
    end
    bus.stall = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[2]) begin n_fails++; $display("FAIL unstall_instr: got %h expected %h", bus.if_id_instr, mem[2]); end
    n_checks++; if (bus.if_id_pc !== 32'd2) begin n_fails++; $display("FAIL unstall_ifpc: got %h expected 2", bus.if_id_pc); end
    n_checks++; if (bus.instr_count !== 32'd3) begin n_fails++; $display("FAIL unstall_count: got %0d expected 3", bus.instr_count); end
  endtask

  task automatic test_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd0;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL redir_valid: got %b expected 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL redir_instr: got %h expected %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.imem_addr !== 32'd0) begin n_fails++; $display("FAIL redir_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (bus.instr_count !== 32'd3) begin n_fails++; $display("FAIL redir_count: got %0d expected 3", bus.instr_count); end
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[0]) begin n_fails++; $display("FAIL redir_tgt_instr: got %h expected %h", bus.if_id_instr, mem[0]); end
    n_checks++; if (bus.if_id_pc !== 32'd0) begin n_fails++; $display("FAIL redir_tgt_pc: got %h expected 0", bus.if_id_pc); end
    n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fails++; $display("FAIL redir_tgt_valid: got %b expected 1", bus.if_id_valid); end
    n_checks++; if (bus.instr_count !== 32'd4) begin n_fails++; $display("FAIL redir_tgt_count: got %0d expected 4", bus.instr_count); end
  endtask

  task automatic test_redirect_stall();
    n_checks++; if (bus.imem_addr !== 32'd1) begin n_fails++; $display("FAIL rs_pre_addr: got %h expected 1", bus.imem_addr); end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd3;
    bus.stall = 1'b1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    n_checks++; if (bus.imem_addr !== 32'd3) begin n_fails++; $display("FAIL rs_addr: got %h expected 3", bus.imem_addr); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL rs_valid: got %b expected 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL rs_instr: got %h expected %h", bus.if_id_instr, NOP); end
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[3]) begin n_fails++; $display("FAIL rs_tgt_instr: got %h expected %h", bus.if_id_instr, mem[3]); end
    n_checks++; if (bus.if_id_pc !== 32'd3) begin n_fails++; $display("FAIL rs_tgt_pc: got %h expected 3", bus.if_id_pc); end
    n_checks++; if (bus.instr_count !== 32'd5) begin n_fails++; $display("FAIL rs_tgt_count: got %0d expected 5", bus.instr_count); end
    n_checks++; if (bus.fetch_done !== 1'b1) begin n_fails++; $display("FAIL rs_done: got %b expected 1", bus.fetch_done); end
  endtask

  task automatic test_halted_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd7;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.imem_addr !== 32'd7) begin n_fails++; $display("FAIL h7_addr: got %h expected 7", bus.imem_addr); end
    n_checks++; if (bus.fetch_done !== 1'b1) begin n_fails++; $display("FAIL h7_done: got %b expected 1", bus.fetch_done); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL h7_valid: got %b expected 0", bus.if_id_valid); end
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL h7_valid2: got %b expected 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL h7_instr2: got %h expected %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.instr_count !== 32'd5) begin n_fails++; $display("FAIL h7_count: got %0d expected 5", bus.instr_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd1;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.fetch_done !== 1'b0) begin n_fails++; $display("FAIL h1_done: got %b expected 0", bus.fetch_done); end
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL h1_valid: got %b expected 0", bus.if_id_valid); end
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[1]) begin n_fails++; $display("FAIL h1_instr: got %h expected %h", bus.if_id_instr, mem[1]); end
    n_checks++; if (bus.if_id_valid !== 1'b1) begin n_fails++; $display("FAIL h1_valid2: got %b expected 1", bus.if_id_valid); end
    n_checks++; if (bus.if_id_pc !== 32'd1) begin n_fails++; $display("FAIL h1_pc: got %h expected 1", bus.if_id_pc); end
    n_checks++; if (bus.instr_count !== 32'd6) begin n_fails++; $display("FAIL h1_count: got %0d expected 6", bus.instr_count); end
  endtask

  task automatic test_async_reset();
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.if_id_valid !== 1'b0) begin n_fails++; $display("FAIL ar_valid: got %b expected 0", bus.if_id_valid); end
    n_checks++; if (bus.if_id_instr !== NOP) begin n_fails++; $display("FAIL ar_instr: got %h expected %h", bus.if_id_instr, NOP); end
    n_checks++; if (bus.instr_count !== 32'd0) begin n_fails++; $display("FAIL ar_count: got %0d expected 0", bus.instr_count); end
    n_checks++; if (bus.imem_addr !== 32'd0) begin n_fails++; $display("FAIL ar_addr: got %h expected 0", bus.imem_addr); end
    n_checks++; if (bus.if_id_pc !== 32'd0) begin n_fails++; $display("FAIL ar_pc: got %h expected 0", bus.if_id_pc); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.if_id_instr !== mem[0]) begin n_fails++; $display("FAIL ar_first_instr: got %h expected %h", bus.if_id_instr, mem[0]); end
    n_checks++; if (bus.instr_count !== 32'd1) begin n_fails++; $display("FAIL ar_first_count: got %0d expected 1", bus.instr_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halted_redirect();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
